// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared constants and encodings for the Montgomery exponentiation sequencer
package mont_pkg;

  localparam int DEF_LENGTH = 16;
  localparam int DEF_EXP_W  = 16;
  localparam int NUM_OPS    = 3 + 2 * DEF_EXP_W;
  // Montgomery radix R = 2^R_EXP
  localparam int R_EXP      = DEF_LENGTH + 1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CONV_B   = 3'd1;
  localparam state_t ST_CONV_ONE = 3'd2;
  localparam state_t ST_SQR      = 3'd3;
  localparam state_t ST_MUL      = 3'd4;
  localparam state_t ST_OUT      = 3'd5;
  localparam state_t ST_FIN      = 3'd6;

  typedef logic phase_t;
  localparam phase_t PH_ISSUE = 1'b0;
  localparam phase_t PH_WAIT  = 1'b1;

endpackage

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - constant-time left-to-right square-and-multiply sequencer for an external Montgomery multiplier
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LENGTH-1:0] base,
  input  logic [EXP_W-1:0]  exp,
  input  logic [LENGTH-2:0] n,
  input  logic [LENGTH-1:0] r2,
  output logic              busy,
  output logic              done,
  output logic [LENGTH-1:0] result,
  output logic              mm_start,
  output logic [LENGTH-1:0] mm_x,
  output logic [LENGTH-1:0] mm_y,
  output logic [LENGTH-2:0] mm_n,
  input  logic [LENGTH-1:0] mm_t,
  input  logic              mm_done
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [LENGTH-1:0] ONE = LENGTH'(1);

  state_t            state;
  phase_t            phase;
  logic [LENGTH-1:0] base_q;
  logic [EXP_W-1:0]  exp_q;
  logic [LENGTH-2:0] n_q;
  logic [LENGTH-1:0] r2_q;
  logic [LENGTH-1:0] acc;
  logic [LENGTH-1:0] bm;
  logic [LENGTH-1:0] res_q;
  logic [IDX_W-1:0]  bit_idx;
  logic [LENGTH-1:0] op_x;
  logic [LENGTH-1:0] op_y;
  logic [LENGTH-1:0] n_ext;

  assign mm_n  = n_q;
  assign n_ext = {1'b0, n_q};

  always_comb begin
    op_x = '0;
    op_y = '0;
    case (state)
      ST_CONV_B:   begin op_x = base_q; op_y = r2_q; end
      ST_CONV_ONE: begin op_x = ONE;    op_y = r2_q; end
      ST_SQR:      begin op_x = acc;    op_y = acc;  end
      ST_MUL:      begin op_x = acc;    op_y = bm;   end
      ST_OUT:      begin op_x = acc;    op_y = ONE;  end
      default:     begin op_x = '0;     op_y = '0;   end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= PH_ISSUE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_x     <= '0;
      mm_y     <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      r2_q     <= '0;
      acc      <= '0;
      bm       <= '0;
      res_q    <= '0;
      bit_idx  <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exp;
            n_q     <= n;
            r2_q    <= r2;
            bit_idx <= IDX_W'(EXP_W - 1);
            busy    <= 1'b1;
            phase   <= PH_ISSUE;
            state   <= ST_CONV_B;
          end
        end
        ST_FIN: begin
          // result only moves together with done so it stays stable between jobs
          result <= res_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_CONV_B, ST_CONV_ONE, ST_SQR, ST_MUL, ST_OUT: begin
          if (phase == PH_ISSUE) begin
            mm_x     <= op_x;
            mm_y     <= op_y;
            mm_start <= 1'b1;
            phase    <= PH_WAIT;
          end else if (mm_done) begin
            phase <= PH_ISSUE;
            case (state)
              ST_CONV_B: begin
                bm    <= mm_t;
                state <= ST_CONV_ONE;
              end
              ST_CONV_ONE: begin
                acc   <= mm_t;
                state <= ST_SQR;
              end
              ST_SQR: begin
                acc   <= mm_t;
                state <= ST_MUL;
              end
              ST_MUL: begin
                // multiply always runs; a zero bit simply discards the product
                if (exp_q[bit_idx]) acc <= mm_t;
                if (bit_idx == '0) begin
                  state <= ST_OUT;
                end else begin
                  bit_idx <= bit_idx - 1'b1;
                  state   <= ST_SQR;
                end
              end
              default: begin
                res_q <= (mm_t >= n_ext) ? (mm_t - n_ext) : mm_t;
                state <= ST_FIN;
              end
            endcase
          end
        end
        default: begin
          busy  <= 1'b0;
          phase <= PH_ISSUE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

Constant-time modular exponentiation sequencer that drives one external Montgomery multiplier core through its start/done handshake. It computes result = base^exp mod N using left-to-right square-and-multiply in the Montgomery domain. It handles entry into and exit from the Montgomery domain with the host-supplied constant R² mod N. It sits between the host/register interface and the multiplier instance.

## Interface
- LENGTH, 16, multiplier operand width; Montgomery radix R = 2^(LENGTH+1)
- EXP_W, 16, exponent width in bits
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- base  in  LENGTH  plain-domain base, must be < N
- exp  in  EXP_W  exponent
- n  in  LENGTH-1  odd modulus
- r2  in  LENGTH  R² mod N
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  LENGTH  base^exp mod N, fully reduced; held until the next done
- mm_start  out  1  one-cycle pulse to the multiplier
- mm_x, mm_y  out  LENGTH  multiplier operands
- mm_n  out  LENGTH-1  modulus to the multiplier
- mm_t  in  LENGTH  multiplier result
- mm_done  in  1  multiplier completion pulse

## Operation
- Reset values: busy=0, done=0, result=0, mm_start=0, mm_x=mm_y=0, mm_n=0. FSM is in IDLE.
- On start in IDLE:
  - latch base, exp, n and r2 into registers;
  - load a bit index with EXP_W-1;
  - go to CONV_B.
- States and operations (MM(a,b) = a·b·R⁻¹ mod N):
  - IDLE
  - CONV_B: bm = MM(base, r2)
  - CONV_ONE: acc = MM(1, r2)
  - SQR: acc = MM(acc, acc)
  - MUL: tmp = MM(acc, bm)
  - OUT: res = MM(acc, 1)
- Each operation state has two phases:
  - ISSUE: drive mm_x/mm_y, pulse mm_start for one cycle.
  - WAIT: hold the operands until mm_done, then capture mm_t on that edge.
- Sequence: CONV_B → CONV_ONE → (SQR → MUL) once per exponent bit, MSB first → OUT → IDLE.
- MUL always executes. On capture:
  - acc ← mm_t if exp bit = 1;
  - acc is unchanged if the bit = 0.
  - The operation count is therefore exactly 3 + 2·EXP_W regardless of exp (constant time).
- After MUL, decrement the bit index. When the index reaches 0, go to OUT instead of SQR.
- OUT capture: result ← (mm_t ≥ N) ? mm_t − N : mm_t. done pulses on the next cycle, then the FSM returns to IDLE.
- mm_n is driven from the latched n for the whole job.
- start while busy is ignored. Input changes after acceptance have no effect.
- mm_done outside WAIT is ignored.

## Timing
- mm_start rises one cycle after the state enters an ISSUE phase. The next ISSUE begins the cycle after mm_done is captured, so back-to-back starts are one cycle after the multiplier's done.
- No fixed multiplier latency is assumed. Job latency = (3 + 2·EXP_W)·(L_mm + 2) + 2 cycles from start, where L_mm is the cycles from mm_start to mm_done.
- busy falls in the same cycle done pulses.
- Reset mid-job: everything returns to reset values immediately and no done is produced. The multiplier shares rst_n at top level.
- exp = 0: all MULs are discarded and result = 1 (for N > 1).

## Structure
- Shared package mont_pkg:
  - FSM state enum;
  - phase encoding;
  - localparam NUM_OPS = 3 + 2·EXP_W;
  - the Montgomery R definition for LENGTH.
- No sub-module. The multiplier is instantiated beside this block in a top-level wrapper mont_exp_top. The bench uses a behavioral MM model with a programmable L_mm.

## Test plan
All cases use LENGTH=16 and EXP_W=16, so R = 2^17.
- N=13, r2=10, base=2, exp=5 → result=6; exactly 35 mm_start pulses; a single done pulse.
- N=13, r2=10, base=2, exp=0xFFFF → result=8; same 35 pulses. Job length equals the exp=5 job for the same L_mm.
- N=13, r2=10, base=7, exp=0 → result=1. base=0, exp=7 → result=0.
- Randomized L_mm (1–40) with 200 random odd N, base<N and exp, against a reference pow mod → all match. mm_x/mm_y stay stable throughout every WAIT.
- Assert start again mid-job with different operands → ignored; the first job's result is unchanged.
- Drop rst_n during the 10th MM operation → busy=0, done=0, mm_start=0 asynchronously. A fresh start after release completes correctly.
